instr_fetch_unit: RTL and testbench

Instruction fetch stage feeding the decode/control path. It keeps the program counter and reads 32-bit instruction words from a synchronous instruction ROM. Each fetched word is presented with its PC and its split MIPS fields (opcode, rs, rt, rd, shamt, funct) under a valid/stall handshake. Branch redirects are supported with a one-bubble flush, and an optional halt detector is available.

---
 rtl/instr_fetch_unit_pkg.sv | 43 ++++
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit_instr_rom.sv | 19 +
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: MIPS field layout,
// reserved instruction words and the fetch FSM state encoding.
// The HALT state exists only when FETCH_HALT_EN is defined.
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_W   = 32;

    // MIPS instruction field positions and widths
    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned OPC_W     = 6;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned FUNCT_W   = 6;

    localparam logic [OPC_W-1:0]   OPC_RTYPE = 6'b000000;
    localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;
`endif

    // Clear the byte-offset bits of an address
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode bus: stall/redirect controls in, fetched word, PC and
// decoded MIPS fields out. The fetch unit is the master.
interface instr_fetch_unit_if;

    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic        halted;

    modport master (
        input  stall, branchTaken, branchTarget,
        output instrValid, instrOut, pcOut, pcPlus4,
               opcode, rs, rt, rd, shamt, funct, halted
    );

    modport slave (
        output stall, branchTaken, branchTarget,
        input  instrValid, instrOut, pcOut, pcPlus4,
               opcode, rs, rt, rd, shamt, funct, halted
    );

endinterface

// File: rtl/instr_fetch_unit_instr_rom.sv
// Synchronous-read instruction ROM, one-cycle latency, 2^ADDR_W words.
// Contents are written into mem by the environment; MEM_FILE is kept for
// interface compatibility.
module instr_rom #(
  parameter int unsigned ADDR_W   = 8,
  parameter string       MEM_FILE = "program.mem"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC management, ROM sequencing, stall hold and
// one-bubble branch redirect. Optional halt detection under FETCH_HALT_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter string       MEM_FILE = "program.mem"
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    fetch_state_t      state;
    logic [31:0]       fetch_pc;   // next sequential read address
    logic [31:0]       flight_pc;  // address of the word on rom_data
    logic [31:0]       read_pc;    // address presented to the ROM this cycle
    logic [31:0]       rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic              redirect;
    logic              hold;
    logic              unused_pc_bits;
`ifdef FETCH_HALT_EN
    logic              halt_hit;
`endif

    // Choose this cycle's ROM address. A stall re-reads the in-flight word so
    // rom_data stays aligned with flight_pc; a redirect reads the target now,
    // which makes FLUSH the single bubble cycle.
    always_comb begin
        redirect = (state == ST_RUN) && bus.branchTaken && bus.instrValid;
        hold     = ((state == ST_RUN) || (state == ST_FLUSH)) && bus.stall && !redirect;
`ifdef FETCH_HALT_EN
        halt_hit = (state == ST_RUN) && bus.instrValid && (bus.instrOut == HALT_WORD);
        if (halt_hit) redirect = 1'b0;
        hold = hold || halt_hit || (state == ST_HALT);
`endif
        read_pc = fetch_pc;
        if (redirect)  read_pc = word_align(bus.branchTarget);
        else if (hold) read_pc = flight_pc;
    end

    assign rom_addr       = read_pc[ADDR_W+1:2];
    assign unused_pc_bits = ^{read_pc[31:ADDR_W+2], read_pc[1:0]};

    instr_rom #(
        .ADDR_W  (ADDR_W),
        .MEM_FILE(MEM_FILE)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .rdata(rom_data)
    );

    // Fetch FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_FILL;
            fetch_pc       <= word_align(RESET_PC);
            flight_pc      <= word_align(RESET_PC);
            bus.instrValid <= 1'b0;
            bus.instrOut   <= NOP_WORD;
            bus.pcOut      <= '0;
`ifdef FETCH_HALT_EN
            bus.halted     <= 1'b0;
`endif
        end else begin
            if (!hold) begin
                flight_pc <= read_pc;
                fetch_pc  <= read_pc + 32'd4;
            end
            case (state)
                ST_FILL: state <= ST_RUN;
                ST_RUN: begin
`ifdef FETCH_HALT_EN
                    if (halt_hit) begin
                        state          <= ST_HALT;
                        bus.instrValid <= 1'b0;
                        bus.instrOut   <= NOP_WORD;
                        bus.halted     <= 1'b1;
                    end else
`endif
                    if (redirect) begin
                        state          <= ST_FLUSH;
                        bus.instrValid <= 1'b0;
                        bus.instrOut   <= NOP_WORD;
                    end else if (!bus.stall) begin
                        bus.instrValid <= 1'b1;
                        bus.instrOut   <= rom_data;
                        bus.pcOut      <= flight_pc;
                    end
                end
                ST_FLUSH: begin
                    if (!bus.stall) begin
                        state          <= ST_RUN;
                        bus.instrValid <= 1'b1;
                        bus.instrOut   <= rom_data;
                        bus.pcOut      <= flight_pc;
                    end
                end
`ifdef FETCH_HALT_EN
                ST_HALT: state <= ST_HALT;
`endif
                default: state <= ST_FILL;
            endcase
        end
    end

    // Field slices of the registered word
    always_comb begin
        bus.pcPlus4 = bus.pcOut + 32'd4;
        bus.opcode  = bus.instrOut[OPC_LSB +: OPC_W];
        bus.rs      = bus.instrOut[RS_LSB +: REG_W];
        bus.rt      = bus.instrOut[RT_LSB +: REG_W];
        bus.rd      = bus.instrOut[RD_LSB +: REG_W];
        bus.shamt   = bus.instrOut[SHAMT_LSB +: REG_W];
        bus.funct   = bus.instrOut[FUNCT_LSB +: FUNCT_W];
    end

`ifndef FETCH_HALT_EN
    assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, stream, stall, branch,
// wrap and halt behaviour, with a queue of expected outputs.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if m_if ();
    instr_fetch_unit_if w_if ();
    instr_fetch_unit_if h_if ();

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0), .MEM_FILE("")) u_main (
        .clk(clk), .rst_n(rst_n), .bus(m_if));
    instr_fetch_unit #(.ADDR_W(2), .RESET_PC(32'hC), .MEM_FILE("")) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(w_if));
    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0), .MEM_FILE("")) u_halt (
        .clk(clk), .rst_n(rst_n), .bus(h_if));

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] w;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] W0 = 32'h0123_4820;
    localparam logic [31:0] W1 = 32'h014B_6022;
    localparam logic [31:0] W2 = 32'h018D_7024;
    localparam logic [31:0] W3 = 32'h01CF_8025;

    function automatic logic [31:0] mword(input int unsigned i);
        return 32'h0000_0020 + (i << 11);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic v, input logic [31:0] pc, input logic [31:0] w);
        exp_t e;
        e.v = v; e.pc = pc; e.w = w;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, m_if.pcOut);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(m_if.instrValid), 32'(e.v));
            chk({tag, "_instr"}, m_if.instrOut, e.w);
            if (e.v) chk({tag, "_pc"}, m_if.pcOut, e.pc);
        end
    endtask

    initial begin
        m_if.stall = 1'b0; m_if.branchTaken = 1'b0; m_if.branchTarget = '0;
        w_if.stall = 1'b0; w_if.branchTaken = 1'b0; w_if.branchTarget = '0;
        h_if.stall = 1'b0; h_if.branchTaken = 1'b0; h_if.branchTarget = '0;

        for (int i = 0; i < 256; i++) begin
            u_main.u_rom.mem[i] = mword(i);
            u_halt.u_rom.mem[i] = mword(i);
        end
        u_main.u_rom.mem[0] = W0;
        u_main.u_rom.mem[1] = W1;
        u_main.u_rom.mem[2] = W2;
        u_main.u_rom.mem[3] = W3;
        u_halt.u_rom.mem[2] = HALT_WORD;
        for (int i = 0; i < 4; i++) u_wrap.u_rom.mem[i] = 32'hA000_0000 + i;

        // Reset state
        tick(); tick();
        chk("rst_valid",  32'(m_if.instrValid), 32'h0);
        chk("rst_instr",  m_if.instrOut, 32'h0);
        chk("rst_pc",     m_if.pcOut, 32'h0);
        chk("rst_halted", 32'(m_if.halted), 32'h0);
        chk("rst_funct",  32'(m_if.funct), 32'h0);

        // FILL then first word
        rst_n = 1'b1;
        tick();
        chk("fill_valid", 32'(m_if.instrValid), 32'h0);
        push(1'b1, 32'h0, W0);
        tick();
        pop_check("first");
        chk("first_opcode", 32'(m_if.opcode), 32'h0);
        chk("first_rs",     32'(m_if.rs), 32'd9);
        chk("first_rt",     32'(m_if.rt), 32'd3);
        chk("first_rd",     32'(m_if.rd), 32'd9);
        chk("first_shamt",  32'(m_if.shamt), 32'd0);
        chk("first_funct",  32'(m_if.funct), 32'h20);
        chk("first_pc4",    m_if.pcPlus4, 32'h4);

        // Sequential stream
        push(1'b1, 32'h4, W1); tick(); pop_check("seq4");
        push(1'b1, 32'h8, W2); tick(); pop_check("seq8");

        // Stall for 3 cycles at pcOut=8
        m_if.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 32'h8, W2); tick(); pop_check("stall");
        end
        m_if.stall = 1'b0;
        push(1'b1, 32'hC, W3);       tick(); pop_check("resume12");
        push(1'b1, 32'h10, mword(4)); tick(); pop_check("seq16");

        // Steer back to pc 4
        m_if.branchTaken = 1'b1; m_if.branchTarget = 32'h4;
        push(1'b0, 32'h0, NOP_WORD); tick(); m_if.branchTaken = 1'b0; pop_check("steer_bub");
        push(1'b1, 32'h4, W1); tick(); pop_check("steer4");

        // Branch to 0x43 (offset bits ignored); branch during bubble ignored
        m_if.branchTaken = 1'b1; m_if.branchTarget = 32'h43;
        push(1'b0, 32'h0, NOP_WORD); tick();
        m_if.branchTarget = 32'h80;
        pop_check("br_bub");
        push(1'b1, 32'h40, mword(16)); tick(); m_if.branchTaken = 1'b0; pop_check("br_tgt");
        push(1'b1, 32'h44, mword(17)); tick(); pop_check("br_next");

        // Steer to 4 again, then branch with simultaneous stall
        m_if.branchTaken = 1'b1; m_if.branchTarget = 32'h4;
        push(1'b0, 32'h0, NOP_WORD); tick(); m_if.branchTaken = 1'b0; pop_check("steer2_bub");
        push(1'b1, 32'h4, W1); tick(); pop_check("steer2_4");
        m_if.branchTaken = 1'b1; m_if.stall = 1'b1; m_if.branchTarget = 32'h40;
        push(1'b0, 32'h0, NOP_WORD); tick();
        m_if.branchTaken = 1'b0; m_if.stall = 1'b0;
        pop_check("brst_bub");
        push(1'b1, 32'h40, mword(16)); tick(); pop_check("brst_tgt");
        push(1'b1, 32'h44, mword(17)); tick(); pop_check("brst_next");
        chk("brst_pc4", m_if.pcPlus4, 32'h48);

        // Wrap: ADDR_W=2, RESET_PC=0xC
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); tick();
        chk("wrap_valid0", 32'(w_if.instrValid), 32'h1);
        chk("wrap_pc0",    w_if.pcOut, 32'hC);
        chk("wrap_instr0", w_if.instrOut, 32'hA000_0003);
        tick();
        chk("wrap_pc1",    w_if.pcOut, 32'h10);
        chk("wrap_instr1", w_if.instrOut, 32'hA000_0000);
        chk("wrap_pc4",    w_if.pcPlus4, 32'h14);

        // Halt word at ROM[2]
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        chk("halt_word_valid", 32'(h_if.instrValid), 32'h1);
        chk("halt_word_pc",    h_if.pcOut, 32'h8);
        chk("halt_word",       h_if.instrOut, HALT_WORD);
        tick();
`ifdef FETCH_HALT_EN
        chk("halt_halted", 32'(h_if.halted), 32'h1);
        chk("halt_valid",  32'(h_if.instrValid), 32'h0);
        chk("halt_pc",     h_if.pcOut, 32'h8);
        tick(); tick();
        chk("halt_stay",    32'(h_if.halted), 32'h1);
        chk("halt_pc_hold", h_if.pcOut, 32'h8);
        chk("halt_fields",  32'(h_if.opcode), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(h_if.halted), 32'h0);
        chk("halt_rst_pc",     h_if.pcOut, 32'h0);
`else
        chk("nohalt_halted", 32'(h_if.halted), 32'h0);
        chk("nohalt_valid",  32'(h_if.instrValid), 32'h1);
        chk("nohalt_pc",     h_if.pcOut, 32'hC);
        chk("nohalt_instr",  h_if.instrOut, mword(3));
        rst_n = 1'b0;
        #1;
        chk("nohalt_rst_valid", 32'(h_if.instrValid), 32'h0);
`endif
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
